// File: rtl/d_mem_fsm.sv
// d_mem_fsm: data-memory access controller for the MEM stage.
// Turns a pipeline load/store request into a multi-cycle SRAM transaction.
// The pipeline is stalled until the access completes. Load data is
// lane-selected and sign/zero extended before it is returned.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   mem_read, mem_write       load/store request levels (held while d_stall)
//   funct3, addr, wdata       RISC-V width/sign code, byte address, store data
//   mem_rdata                 SRAM read word
//   mem_en, mem_we            SRAM enable / write enable (registered)
//   mem_addr, mem_wdata       word address, lane-replicated store data
//   mem_wmask                 byte-lane write mask
//   d_stall                   pipeline hold (combinational)
//   load_data, load_valid     extended load result, one-cycle valid pulse
//   misalign                  one-cycle pulse on misaligned/illegal access
//   dbg_state                 current FSM state for observation
//
// Handshake: a request is a level on mem_read/mem_write. While d_stall=1 the
// pipeline holds the request stable; the access has completed in the first
// cycle where d_stall=0 (DONE), and the request is dropped after that cycle.
module d_mem_fsm #(
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1,
  parameter int CNT_W  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        d_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic        req;
  logic        bad_f3;
  logic        mis;
  logic        bad;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;

  assign req       = mem_write | mem_read;
  assign dbg_state = state;

  // Legality: a store only knows SB/SH/SW; loads additionally have LBU/LHU.
  // Alignment only depends on the size bits funct3[1:0].
  always_comb begin
    bad_f3 = 1'b0;
    mis    = 1'b0;
    if (mem_write)
      bad_f3 = funct3[2] | (funct3[1:0] == 2'b11);
    else
      bad_f3 = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    case (funct3[1:0])
      2'b01:   mis = addr[0];
      2'b10:   mis = |addr[1:0];
      default: mis = 1'b0;
    endcase
    bad = req & (bad_f3 | mis);
  end

  // Store lanes: data is replicated so every possible lane carries it and
  // the mask alone selects which bytes the SRAM writes.
  always_comb begin
    st_mask = 4'b1111;
    st_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << addr[1:0];
        st_data = {2{wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = wdata;
      end
    endcase
  end

  // Load extraction from the offset latched at request time.
  always_comb begin
    byte_sel = mem_rdata[8*off_q +: 8];
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ld_ext = {24'h0, byte_sel};
      3'b001:  ld_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  ld_ext = {16'h0, half_sel};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Stall covers the accepting IDLE cycle plus every access cycle. Gated by
  // rstn so an asserted reset releases the pipeline even if a request is
  // still being held.
  assign d_stall = rstn & (((state == IDLE) & req & ~bad) |
                           (state == WRITE) | (state == READ));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wmask  <= 4'b0000;
      load_data  <= 32'h0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      case (state)
        IDLE: begin
          if (bad) begin
            misalign <= 1'b1;
          end else if (req) begin
            cnt      <= '0;
            mem_addr <= {addr[31:2], 2'b00};
            f3_q     <= funct3;
            off_q    <= addr[1:0];
            mem_en   <= 1'b1;
            if (mem_write) begin
              mem_we    <= 1'b1;
              mem_wmask <= st_mask;
              mem_wdata <= st_data;
              state     <= WRITE;
            end else begin
              mem_we    <= 1'b0;
              mem_wmask <= 4'b0000;
              state     <= READ;
            end
          end
        end
        WRITE: begin
          cnt <= cnt + 1'b1;
          if (cnt == WR_LAST) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= 4'b0000;
            state     <= DONE;
          end
        end
        READ: begin
          cnt <= cnt + 1'b1;
          if (cnt == RD_LAST) begin
            load_data  <= ld_ext;
            load_valid <= 1'b1;
            mem_en     <= 1'b0;
            state      <= DONE;
          end
        end
        default: begin
          // DONE: the instruction retires here; any request is its own.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_mem_fsm.sv
// tb_d_mem_fsm: self-checking bench for d_mem_fsm with a small SRAM model
// that presents read data only in the RD_LAT-th read cycle.
module tb_d_mem_fsm;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        d_stall;
  logic [31:0] load_data;
  logic        load_valid, misalign;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  d_mem_fsm #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .d_stall(d_stall),
    .load_data(load_data), .load_valid(load_valid), .misalign(misalign),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  logic [31:0] exp_q[$];
  wr_t         exp_wr_q[$];
  wr_t         mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          en_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- SRAM read model ----------------
  logic [31:0] rd_word = 32'h0;
  int          rd_cyc;
  always @(negedge clk or negedge rstn)
    if (!rstn) rd_cyc <= 0;
    else       rd_cyc <= (mem_en && !mem_we) ? rd_cyc + 1 : 0;
  assign mem_rdata = (rd_cyc == RD_LAT) ? rd_word : ~rd_word;

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (rstn) begin
      if (mem_en) en_cycles++;
      if (mem_en && mem_we) begin
        if (exp_wr_q.size() == 0) check("unexp_write", 32'd1, 32'd0);
        else begin
          mon_e = exp_wr_q.pop_front();
          check("mem_addr",  mem_addr,  mon_e.a);
          check("mem_wdata", mem_wdata, mon_e.d);
          check("mem_wmask", {28'h0, mem_wmask}, {28'h0, mon_e.m});
        end
      end
      if (mem_en && !mem_we) check("rd_wmask", {28'h0, mem_wmask}, 32'h0);
      if (load_valid) begin
        if (exp_q.size() == 0) check("unexp_load", 32'd1, 32'd0);
        else check("load_data", load_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic wr_t ref_store(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd);
    wr_t r;
    int  nb;
    nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    r.a = {a[31:2], 2'b00};
    r.d = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
    for (int i = 0; i < 4; i++)
      r.m[i] = (nb == 4) || (i >= int'(a[1:0]) && i < int'(a[1:0]) + nb);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int exp_stall, input string tag);
    int cnt;
    cnt = 0;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    while (d_stall && cnt < 50) begin
      cnt++;
      if (cnt == 2) check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
      @(negedge clk);
    end
    check({tag, "_stall"}, cnt, exp_stall);
    check({tag, "_lvalid"}, {31'h0, load_valid}, {31'h0, rd && !wr});
    check({tag, "_en_done"}, {31'h0, mem_en}, 32'h0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] m, input logic [31:0] d, input string tag);
    wr_t e;
    e.a = {a[31:2], 2'b00}; e.d = d; e.m = m;
    exp_wr_q.push_back(e);
    access(1'b0, 1'b1, f3, a, wd, WR_LAT + 1, tag);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] exp, input string tag);
    rd_word = w;
    exp_q.push_back(exp);
    access(1'b1, 1'b0, f3, a, 32'h0, RD_LAT + 1, tag);
  endtask

  task automatic do_bad(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input string tag);
    int en0;
    en0 = en_cycles;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check({tag, "_stall"}, {31'h0, d_stall}, 32'h0);
    check({tag, "_mis_early"}, {31'h0, misalign}, 32'h0);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check({tag, "_mis"}, {31'h0, misalign}, 32'h1);
    @(negedge clk);
    check({tag, "_mis_end"}, {31'h0, misalign}, 32'h0);
    check({tag, "_no_en"}, en_cycles, en0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] ld_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, w;
    wr_t         e;

    rstn = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_en",    {31'h0, mem_en}, 32'h0);
    check("rst_we",    {31'h0, mem_we}, 32'h0);
    check("rst_addr",  mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_mask",  {28'h0, mem_wmask}, 32'h0);
    check("rst_ldata", load_data, 32'h0);
    check("rst_flags", {29'h0, d_stall, load_valid, misalign}, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_store(3'b010, 32'h100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, "sw");
    do_store(3'b000, 32'h103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, "sb");
    do_store(3'b001, 32'h102, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, "sh");
    do_load(3'b000, 32'h202, 32'h0080_FF00, 32'hFFFF_FF80, "lb");
    do_load(3'b100, 32'h202, 32'h0080_FF00, 32'h0000_0080, "lbu");
    do_load(3'b001, 32'h302, 32'h8001_7FFF, 32'hFFFF_8001, "lh");
    do_load(3'b101, 32'h302, 32'h8001_7FFF, 32'h0000_8001, "lhu");
    do_load(3'b010, 32'h304, 32'hCAFE_F00D, 32'hCAFE_F00D, "lw");
    check("ldata_hold", load_data, 32'hCAFE_F00D);

    do_bad(1'b1, 1'b0, 3'b001, 32'h301, "lh_mis");
    do_bad(1'b1, 1'b0, 3'b011, 32'h300, "ld_ill");
    do_bad(1'b0, 1'b1, 3'b010, 32'h102, "sw_mis");
    do_bad(1'b0, 1'b1, 3'b011, 32'h100, "st_ill");

    // Both requests: the store wins, no load retires.
    e.a = 32'h500; e.d = 32'h1234_5678; e.m = 4'b1111;
    exp_wr_q.push_back(e);
    access(1'b1, 1'b1, 3'b010, 32'h500, 32'h1234_5678, WR_LAT + 1, "both");

    // Reset in the first READ cycle abandons the load.
    rd_word = 32'h1111_2222;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;
    check("abort_en_pre", {31'h0, mem_en}, 32'h1);
    rstn = 1'b0;
    #1;
    check("abort_en",    {31'h0, mem_en}, 32'h0);
    check("abort_we",    {31'h0, mem_we}, 32'h0);
    check("abort_stall", {31'h0, d_stall}, 32'h0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    do_store(3'b010, 32'h600, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, "sw_post");

    // Random legal traffic checked against the reference model.
    for (int i = 0; i < 24; i++) begin
      a = {$urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF)};
      w = {$urandom_range(0, 32'hFFFF), $urandom_range(0, 32'hFFFF)};
      if ($urandom_range(0, 1) == 1) begin
        f3 = ld_codes[$urandom_range(0, 4)];
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        do_load(f3, a, w, ref_load(f3, a[1:0], w), "rnd_ld");
      end else begin
        f3 = 3'($urandom_range(0, 2));
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        e = ref_store(f3, a, w);
        exp_wr_q.push_back(e);
        access(1'b0, 1'b1, f3, a, w, WR_LAT + 1, "rnd_st");
      end
    end

    repeat (2) @(negedge clk);
    check("ld_q_empty", exp_q.size(), 32'd0);
    check("wr_q_empty", exp_wr_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
